adc_sample_sequencer: RTL and testbench

Paced controller for the dual-channel (I/Q) 8-bit ADC front end. Issues periodic conversion-start pulses, waits for end-of-conversion with a timeout, then captures both channels. Converts each capture to a 9-bit signed offset-binary value (2·x − 255) and delivers it downstream on a valid/ready handshake with frame markers. Sits between the ADC pins and the DSP chain; it replaces free-running eoc-clocked capture with a single-clock, sequenced datapath.

---
 rtl/adc_sample_sequencer_if.sv | 28 ++
 rtl/adc_sample_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_adc_sample_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_sample_sequencer_if.sv
// Sample stream from the ADC sequencer to the DSP chain.
// The master drives data, flags and valid; the slave drives ready.
interface adc_sample_sequencer_if;
    logic signed [8:0] sample_real;
    logic signed [8:0] sample_imag;
    logic              sample_valid;
    logic              sample_ready;
    logic              frame_start;
    logic              frame_end;

    modport master (
        output sample_real,
        output sample_imag,
        output sample_valid,
        output frame_start,
        output frame_end,
        input  sample_ready
    );

    modport slave (
        input  sample_real,
        input  sample_imag,
        input  sample_valid,
        input  frame_start,
        input  frame_end,
        output sample_ready
    );
endinterface

// File: rtl/adc_sample_sequencer.sv
// Paced I/Q ADC controller: start pulse, eoc wait with timeout,
// capture, offset-binary conversion and framed valid/ready output.
module adc_sample_sequencer #(
    parameter int DIV       = 64,
    parameter int TIMEOUT   = 32,
    parameter int FRAME_LEN = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       err_clr,
    input  logic       adc_eoc,
    input  logic [7:0] adc_data_real,
    input  logic [7:0] adc_data_imag,
    output logic       adc_start,
    output logic       overrun,
    output logic       timeout_err,
    output logic       busy,
    adc_sample_sequencer_if.master smp
);
    localparam int CW = $clog2(DIV);
    localparam int TW = $clog2(TIMEOUT);
    localparam int IW = $clog2(FRAME_LEN);

    typedef enum logic [2:0] {
        IDLE, WAIT_TICK, START, WAIT_EOC, OUTPUT
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] toc_q, toc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [8:0] re_q, re_d, im_q, im_d;
    logic fs_q, fs_d, fe_q, fe_d;
    logic valid_q, valid_d;
    logic start_q, start_d;
    logic ovr_q, ovr_d, tmo_q, tmo_d;
    logic busy_q, busy_d;
    logic eoc_s1_q, eoc_s2_q, eoc_s3_q;
    logic eoc_rise, tick;

    // 2*x - 255 in 10 bits, truncated to a 9-bit signed value
    function automatic logic [8:0] to_s9(input logic [7:0] x);
        logic [9:0] w;
        w = {1'b0, x, 1'b0} - 10'd255;
        return w[8:0];
    endfunction

    assign eoc_rise = eoc_s2_q & ~eoc_s3_q;
    assign tick = enable && (state_q != IDLE) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        toc_d   = toc_q;
        idx_d   = idx_q;
        re_d    = re_q;
        im_d    = im_q;
        fs_d    = fs_q;
        fe_d    = fe_q;
        valid_d = valid_q;
        start_d = 1'b0;
        ovr_d   = ovr_q & ~err_clr;
        tmo_d   = tmo_q & ~err_clr;

        if (state_q == IDLE || (!enable && state_q != OUTPUT))
            cnt_d = '0;
        else if (enable)
            cnt_d = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);

        // ticks outside WAIT_TICK are dropped; the grid keeps running
        if (tick && state_q != WAIT_TICK)
            ovr_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (enable) state_d = WAIT_TICK;
            end
            WAIT_TICK: begin
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (tick) begin
                    state_d = START;
                    start_d = 1'b1;
                end
            end
            START: begin
                toc_d = '0;
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    state_d = WAIT_EOC;
                end
            end
            WAIT_EOC: begin
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (eoc_rise) begin
                    re_d    = to_s9(adc_data_real);
                    im_d    = to_s9(adc_data_imag);
                    fs_d    = (idx_q == '0);
                    fe_d    = (idx_q == IW'(FRAME_LEN - 1));
                    valid_d = 1'b1;
                    state_d = OUTPUT;
                end else if (toc_q == TW'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = WAIT_TICK;
                end else begin
                    toc_d = toc_q + TW'(1);
                end
            end
            OUTPUT: begin
                if (smp.sample_ready) begin
                    valid_d = 1'b0;
                    fs_d    = 1'b0;
                    fe_d    = 1'b0;
                    if (enable) begin
                        idx_d   = (idx_q == IW'(FRAME_LEN - 1)) ?
                                  '0 : idx_q + IW'(1);
                        state_d = WAIT_TICK;
                    end else begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            toc_q    <= '0;
            idx_q    <= '0;
            re_q     <= '0;
            im_q     <= '0;
            fs_q     <= 1'b0;
            fe_q     <= 1'b0;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            ovr_q    <= 1'b0;
            tmo_q    <= 1'b0;
            busy_q   <= 1'b0;
            eoc_s1_q <= 1'b0;
            eoc_s2_q <= 1'b0;
            eoc_s3_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            toc_q    <= toc_d;
            idx_q    <= idx_d;
            re_q     <= re_d;
            im_q     <= im_d;
            fs_q     <= fs_d;
            fe_q     <= fe_d;
            valid_q  <= valid_d;
            start_q  <= start_d;
            ovr_q    <= ovr_d;
            tmo_q    <= tmo_d;
            busy_q   <= busy_d;
            eoc_s1_q <= adc_eoc;
            eoc_s2_q <= eoc_s1_q;
            eoc_s3_q <= eoc_s2_q;
        end
    end

    assign adc_start        = start_q;
    assign overrun          = ovr_q;
    assign timeout_err      = tmo_q;
    assign busy             = busy_q;
    assign smp.sample_real  = re_q;
    assign smp.sample_imag  = im_q;
    assign smp.sample_valid = valid_q;
    assign smp.frame_start  = fs_q;
    assign smp.frame_end    = fe_q;
endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Testbench for adc_sample_sequencer: vector table, random samples
// against a frame/arithmetic reference, and multi-cycle corner cases.
module tb_adc_sample_sequencer;
    localparam int DIV = 64;
    localparam int TMO = 32;
    localparam int FL  = 4;

    logic clk = 1'b0;
    logic rst_n, enable, err_clr, adc_eoc;
    logic [7:0] adc_data_real, adc_data_imag;
    logic adc_start, overrun, timeout_err, busy;

    adc_sample_sequencer_if sif();

    adc_sample_sequencer #(
        .DIV(DIV), .TIMEOUT(TMO), .FRAME_LEN(FL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .err_clr(err_clr), .adc_eoc(adc_eoc),
        .adc_data_real(adc_data_real),
        .adc_data_imag(adc_data_imag),
        .adc_start(adc_start), .overrun(overrun),
        .timeout_err(timeout_err), .busy(busy),
        .smp(sif)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    int vcnt   = 0;
    int start_t[$];

    bit eoc_en  = 1'b1;
    int eoc_dly = 10;
    int eoc_cyc = 0;
    int nxt_re  = 0;
    int nxt_im  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (adc_start) start_t.push_back(cyc);
        if (sif.sample_valid) vcnt <= vcnt + 1;
    end

    // ADC model: eoc rises eoc_dly cycles after a start pulse
    initial begin
        adc_eoc = 1'b0;
        adc_data_real = 8'h00;
        adc_data_imag = 8'h00;
        forever begin
            @(negedge clk);
            if (adc_start && eoc_en) begin
                repeat (eoc_dly) @(negedge clk);
                adc_data_real = nxt_re[7:0];
                adc_data_imag = nxt_im[7:0];
                adc_eoc = 1'b1;
                eoc_cyc = cyc;
                repeat (3) @(negedge clk);
                adc_eoc = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_start(output int t);
        int s0 = start_t.size();
        int n = 0;
        while (start_t.size() == s0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (start_t.size() == s0) begin
            chk("start_wait", 0, 1);
            t = cyc;
        end else begin
            t = start_t[start_t.size() - 1];
        end
    endtask

    task automatic get_sample(input int hold, output int re, output int im,
                              output int fs, output int fe, output int lat);
        int n = 0;
        bit stable = 1'b1;
        re = 0; im = 0; fs = 0; fe = 0; lat = 0;
        while (!sif.sample_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!sif.sample_valid) begin
            chk("valid_wait", 0, 1);
        end else begin
            lat = cyc - eoc_cyc;
            re = sif.sample_real;
            im = sif.sample_imag;
            fs = int'(sif.frame_start);
            fe = int'(sif.frame_end);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!sif.sample_valid || sif.sample_real != re ||
                    sif.sample_imag != im || sif.frame_start != fs ||
                    sif.frame_end != fe)
                    stable = 1'b0;
            end
            if (hold > 0) chk("hold_stable", int'(stable), 1);
            sif.sample_ready = 1'b1;
            @(negedge clk);
            sif.sample_ready = 1'b0;
            chk("valid_drop", int'(sif.sample_valid), 0);
        end
    endtask

    typedef struct {
        logic [7:0] re;
        logic [7:0] im;
        int exp_re;
        int exp_im;
        int exp_fs;
        int exp_fe;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int c0, a, b, t, r, i, fs, fe, lat, bad, s0, v0, n, nsamp;

        tbl[0] = '{8'h00, 8'hFF, -255,  255, 1, 0};
        tbl[1] = '{8'h80, 8'h7F,    1,   -1, 0, 0};
        tbl[2] = '{8'hFF, 8'h00,  255, -255, 0, 0};
        tbl[3] = '{8'h01, 8'hFE, -253,  253, 0, 1};
        tbl[4] = '{8'h7F, 8'h80,   -1,    1, 1, 0};
        tbl[5] = '{8'h40, 8'hC0, -127,  129, 0, 0};
        tbl[6] = '{8'h10, 8'h20, -223, -191, 0, 0};
        tbl[7] = '{8'hAA, 8'h55,   85,  -85, 0, 1};

        rst_n = 1'b0;
        enable = 1'b0;
        err_clr = 1'b0;
        sif.sample_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_start", int'(adc_start), 0);
        chk("rst_valid", int'(sif.sample_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_flags", int'({sif.frame_start, sif.frame_end}), 0);
        chk("rst_errs", int'({overrun, timeout_err}), 0);
        chk("rst_data", int'({sif.sample_real, sif.sample_imag}), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_no_start", start_t.size(), 0);
        chk("idle_busy", int'(busy), 0);

        // Table-driven conversion and framing
        c0 = cyc;
        enable = 1'b1;
        @(negedge clk);
        chk("busy_on_enable", int'(busy), 1);
        for (int k = 0; k < 8; k++) begin
            nxt_re = int'(tbl[k].re);
            nxt_im = int'(tbl[k].im);
            get_sample(0, r, i, fs, fe, lat);
            chk("tbl_re", r, tbl[k].exp_re);
            chk("tbl_im", i, tbl[k].exp_im);
            chk("tbl_fs", fs, tbl[k].exp_fs);
            chk("tbl_fe", fe, tbl[k].exp_fe);
            chk("tbl_lat", lat, 3);
        end
        chk("first_start", start_t.size() > 0 ? start_t[0] : -1, c0 + 2);
        bad = 0;
        for (int k = 1; k < start_t.size(); k++)
            if (start_t[k] - start_t[k - 1] != DIV) bad++;
        chk("start_period", bad, 0);
        chk("start_count", start_t.size(), 8);
        chk("no_overrun", int'(overrun), 0);

        // Random data and ready delay against the reference model
        nsamp = 8;
        for (int k = 0; k < 12; k++) begin
            nxt_re = int'($urandom_range(0, 255));
            nxt_im = int'($urandom_range(0, 255));
            get_sample(int'($urandom_range(0, 20)), r, i, fs, fe, lat);
            chk("rnd_re", r, 2 * nxt_re - 255);
            chk("rnd_im", i, 2 * nxt_im - 255);
            chk("rnd_fs", fs, int'(nsamp % FL == 0));
            chk("rnd_fe", fe, int'(nsamp % FL == FL - 1));
            chk("rnd_excl", fs & fe, 0);
            nsamp++;
        end
        chk("rnd_no_overrun", int'(overrun), 0);

        // Timeout: no eoc for the next conversion
        eoc_en = 1'b0;
        wait_start(a);
        v0 = vcnt;
        n = 0;
        while (!timeout_err && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_at", cyc - a, TMO + 1);
        chk("tmo_no_valid", vcnt - v0, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("tmo_clr", int'(timeout_err), 0);
        eoc_en = 1'b1;
        nxt_re = 8'h33;
        nxt_im = 8'hCC;
        wait_start(b);
        chk("tmo_restart", b - a, DIV);
        get_sample(0, r, i, fs, fe, lat);
        chk("tmo_next_re", r, 2 * 8'h33 - 255);
        chk("tmo_next_fs", fs, int'(nsamp % FL == 0));
        nsamp++;

        // Backpressure for 150 cycles
        nxt_re = int'($urandom_range(0, 255));
        nxt_im = int'($urandom_range(0, 255));
        wait_start(a);
        s0 = start_t.size();
        get_sample(150, r, i, fs, fe, lat);
        chk("bp_re", r, 2 * nxt_re - 255);
        chk("bp_im", i, 2 * nxt_im - 255);
        chk("bp_fs", fs, int'(nsamp % FL == 0));
        nsamp++;
        chk("bp_no_extra_start", start_t.size() - s0, 0);
        chk("bp_overrun", int'(overrun), 1);
        wait_start(t);
        chk("bp_grid", t - a, 3 * DIV);
        get_sample(0, r, i, fs, fe, lat);
        chk("bp_next_fs", fs, int'(nsamp % FL == 0));
        nsamp++;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("ovr_clr", int'(overrun), 0);

        // Enable drop while waiting for eoc
        wait_start(a);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("drop_busy", int'(busy), 0);
        v0 = vcnt;
        s0 = start_t.size();
        repeat (20) @(negedge clk);
        chk("drop_no_valid", vcnt - v0, 0);
        chk("drop_no_start", start_t.size() - s0, 0);
        chk("drop_idle", int'(busy), 0);
        nsamp = 0;
        nxt_re = 8'h5A;
        nxt_im = 8'hA5;
        enable = 1'b1;
        get_sample(0, r, i, fs, fe, lat);
        chk("reen_fs", fs, 1);
        chk("reen_fe", fe, 0);
        chk("reen_re", r, 2 * 8'h5A - 255);

        // Asynchronous reset with a sample pending
        wait_start(a);
        n = 0;
        while (!sif.sample_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("pend_valid", int'(sif.sample_valid), 1);
        #2;
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        chk("arst_valid", int'(sif.sample_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_data", int'({sif.sample_real, sif.sample_imag}), 0);
        chk("arst_misc", int'({adc_start, sif.frame_start, sif.frame_end,
                               overrun, timeout_err}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = start_t.size();
        repeat (10) @(negedge clk);
        chk("arst_no_start", start_t.size() - s0, 0);
        chk("arst_idle", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
